// File: rtl/led_alert_pkg.sv
// Shared types and helpers for the LED alert controller.
package led_alert_pkg;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    ALERT    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam int EVT_CNT_W = 4;
  localparam int TIMER_W   = 32;

  function automatic int ms_to_cyc(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Acknowledge button conditioning: 2-flop synchronizer plus an optional stability
// filter enabled by LED_ALERT_ACK_DEBOUNCE_EN. Outputs a clean level, no edge.
module btn_debounce
  import led_alert_pkg::*;
`ifdef LED_ALERT_ACK_DEBOUNCE_EN
  #(parameter logic [TIMER_W-1:0] DB_CYC = 1)
`endif
  (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level
);

  logic sync1, sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef LED_ALERT_ACK_DEBOUNCE_EN
  logic [TIMER_W-1:0] cnt;
  logic               clean;

  // Level only follows sync2 after DB_CYC consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      clean <= 1'b0;
    end else if (sync2 != clean) begin
      if (cnt == DB_CYC - 1'b1) begin
        clean <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign level = clean;
`else
  assign level = sync2;
`endif

endmodule

// File: rtl/led_alert_ctrl.sv
// Breathing / alarm-blink / cooldown duty controller feeding the LED PWM stage.
// Optional ack debounce: define LED_ALERT_ACK_DEBOUNCE_EN.
module led_alert_ctrl
  import led_alert_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int WIDTH       = 8,
  parameter int BREATH_MS   = 2000,
  parameter int BLINK_HZ    = 4,
  parameter int COOL_MS     = 1000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fall_evt,
  input  logic                 ack_btn,
  output logic [WIDTH-1:0]     duty,
  output logic                 alarm,
  output logic [1:0]           state,
  output logic [EVT_CNT_W-1:0] evt_cnt
);

  localparam logic [TIMER_W-1:0] STEP_CYC  = TIMER_W'(ms_to_cyc(CLK_HZ, BREATH_MS) >> WIDTH);
  localparam logic [TIMER_W-1:0] BLINK_CYC = TIMER_W'(CLK_HZ / (2 * BLINK_HZ));
  localparam logic [TIMER_W-1:0] COOL_CYC  = TIMER_W'(ms_to_cyc(CLK_HZ, COOL_MS));
  localparam logic [TIMER_W-1:0] DB_CYC    = TIMER_W'(ms_to_cyc(CLK_HZ, DEBOUNCE_MS));
  localparam logic [WIDTH-1:0]   DUTY_MAX  = '1;

  if (STEP_CYC == '0 || BLINK_CYC == '0 || COOL_CYC == '0 || DB_CYC == '0) begin : g_bad_cfg
    $error("led_alert_ctrl: a derived cycle constant is zero");
  end

  state_t             st;
  logic [TIMER_W-1:0] timer;
  logic               dir_up;
  logic               fall_prev, ack_lvl, ack_prev;
  logic               fall_edge, ack_edge;

  btn_debounce
`ifdef LED_ALERT_ACK_DEBOUNCE_EN
    #(.DB_CYC(DB_CYC))
`endif
    u_ack (
    .clk   (clk),
    .rst   (rst),
    .btn   (ack_btn),
    .level (ack_lvl)
  );

  assign fall_edge = fall_evt & ~fall_prev;
  assign ack_edge  = ack_lvl & ~ack_prev;
  assign state     = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= NORMAL;
      duty      <= '0;
      alarm     <= 1'b0;
      evt_cnt   <= '0;
      dir_up    <= 1'b1;
      timer     <= '0;
      fall_prev <= 1'b0;
      ack_prev  <= 1'b0;
    end else begin
      fall_prev <= fall_evt;
      ack_prev  <= ack_lvl;
      if (fall_edge && evt_cnt != '1) evt_cnt <= evt_cnt + 1'b1;

      case (st)
        NORMAL: begin
          if (fall_edge) begin
            st    <= ALERT;
            alarm <= 1'b1;
            duty  <= DUTY_MAX;
            timer <= '0;
          end else if (timer == STEP_CYC - 1'b1) begin
            timer <= '0;
            // Each extreme is held for one step: turn around instead of stepping past it.
            if (dir_up) begin
              if (duty == DUTY_MAX) begin
                dir_up <= 1'b0;
                duty   <= duty - 1'b1;
              end else begin
                duty <= duty + 1'b1;
              end
            end else begin
              if (duty == '0) begin
                dir_up <= 1'b1;
                duty   <= duty + 1'b1;
              end else begin
                duty <= duty - 1'b1;
              end
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ALERT: begin
          // Ack takes priority over a coincident fall edge (which is still counted above).
          if (ack_edge) begin
            st    <= COOLDOWN;
            alarm <= 1'b0;
            duty  <= '0;
            timer <= '0;
          end else if (timer == BLINK_CYC - 1'b1) begin
            timer <= '0;
            duty  <= (duty == DUTY_MAX) ? '0 : DUTY_MAX;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        COOLDOWN: begin
          if (timer == COOL_CYC - 1'b1) begin
            st     <= NORMAL;
            timer  <= '0;
            duty   <= '0;
            dir_up <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          st     <= NORMAL;
          alarm  <= 1'b0;
          duty   <= '0;
          timer  <= '0;
          dir_up <= 1'b1;
        end
      endcase
    end
  end

endmodule
